// File: rtl/parity_frame_tx.sv
// Framed serial transmitter: start bit, LSB-first data, parity bit, stop bit.
// Every output is a register loaded from the next-state values.
module parity_frame_tx #(
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              parity_bit,
  output logic              frame_done
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic          ODD_BIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;

    if (state_q == IDLE) begin
      if (valid) begin
        shift_d = x;
        par_d   = (^x) ^ ODD_BIT;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = START;
      end
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      unique case (state_q)
        START:  state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = PARITY;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        PARITY: state_d = STOP;
        STOP:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe in the same cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  assign ready      = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign parity_bit = par_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: three instances cover even/1-cycle,
// odd/1-cycle and even/2-cycle bit timing.
module tb_parity_frame_tx;

  typedef struct packed {
    int         sel;
    logic [2:0] x;
    logic [15:0] seq;
    int         len;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] x_a [3];
  logic [2:0] valid_v;
  logic [2:0] ready_v, tx_v, busy_v, par_v, done_v;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(3), .PARITY_ODD(0), .BIT_CYCLES(1)) u_even (
    .clk(clk), .rst(rst), .x(x_a[0]), .valid(valid_v[0]), .ready(ready_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .parity_bit(par_v[0]), .frame_done(done_v[0]));

  parity_frame_tx #(.DATA_W(3), .PARITY_ODD(1), .BIT_CYCLES(1)) u_odd (
    .clk(clk), .rst(rst), .x(x_a[1]), .valid(valid_v[1]), .ready(ready_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .parity_bit(par_v[1]), .frame_done(done_v[1]));

  parity_frame_tx #(.DATA_W(3), .PARITY_ODD(0), .BIT_CYCLES(2)) u_bc2 (
    .clk(clk), .rst(rst), .x(x_a[2]), .valid(valid_v[2]), .ready(ready_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .parity_bit(par_v[2]), .frame_done(done_v[2]));

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input int sel, input logic [2:0] xv, input string s,
                              input logic par);
    vec_t v;
    v.sel = sel;
    v.x   = xv;
    v.seq = '0;
    v.len = s.len();
    v.par = par;
    for (int k = 0; k < s.len(); k++) v.seq[k] = (s[k] == "1");
    return v;
  endfunction

  // Called #1 after a posedge while the selected instance is idle. Valid for
  // the selected instance is left high on return so frames can run back to back.
  task automatic send(input vec_t v, input bit disturb);
    int s;
    s = v.sel;
    chk($sformatf("ready_pre[d%0d x%0d]", s, v.x), ready_v[s], 1'b1);
    for (int i = 0; i < 3; i++) valid_v[i] = (i == s);
    x_a[s] = v.x;
    @(posedge clk); #1;
    for (int k = 0; k < v.len; k++) begin
      if (disturb) x_a[s] = 3'($urandom);
      chk($sformatf("tx[d%0d x%0d c%0d]", s, v.x, k), tx_v[s], v.seq[k]);
      chk($sformatf("busy[d%0d x%0d c%0d]", s, v.x, k), busy_v[s], 1'b1);
      chk($sformatf("ready[d%0d x%0d c%0d]", s, v.x, k), ready_v[s], 1'b0);
      chk($sformatf("par[d%0d x%0d c%0d]", s, v.x, k), par_v[s], v.par);
      chk($sformatf("done[d%0d x%0d c%0d]", s, v.x, k), done_v[s], k == v.len - 1);
      @(posedge clk); #1;
    end
    chk($sformatf("idle_tx[d%0d x%0d]", s, v.x), tx_v[s], 1'b1);
    chk($sformatf("idle_ready[d%0d x%0d]", s, v.x), ready_v[s], 1'b1);
    chk($sformatf("idle_busy[d%0d x%0d]", s, v.x), busy_v[s], 1'b0);
    chk($sformatf("idle_done[d%0d x%0d]", s, v.x), done_v[s], 1'b0);
    chk($sformatf("idle_par[d%0d x%0d]", s, v.x), par_v[s], v.par);
  endtask

  vec_t tv [13];

  initial begin
    // even, 1 cycle/bit: sweep 0..7 back to back
    tv[0]  = mk(0, 3'd0, "000001", 1'b0);
    tv[1]  = mk(0, 3'd1, "010011", 1'b1);
    tv[2]  = mk(0, 3'd2, "001011", 1'b1);
    tv[3]  = mk(0, 3'd3, "011001", 1'b0);
    tv[4]  = mk(0, 3'd4, "000111", 1'b1);
    tv[5]  = mk(0, 3'd5, "010101", 1'b0);
    tv[6]  = mk(0, 3'd6, "001101", 1'b0);
    tv[7]  = mk(0, 3'd7, "011111", 1'b1);
    // odd, 1 cycle/bit
    tv[8]  = mk(1, 3'd0, "000011", 1'b1);
    tv[9]  = mk(1, 3'd7, "011101", 1'b0);
    tv[10] = mk(1, 3'd5, "010111", 1'b1);
    // even, 2 cycles/bit
    tv[11] = mk(2, 3'd6, "000011110011", 1'b0);
    tv[12] = mk(2, 3'd1, "001100001111", 1'b1);

    rst = 1'b1;
    valid_v = '0;
    for (int i = 0; i < 3; i++) x_a[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx[d%0d]", i), tx_v[i], 1'b1);
      chk($sformatf("rst_ready[d%0d]", i), ready_v[i], 1'b1);
      chk($sformatf("rst_busy[d%0d]", i), busy_v[i], 1'b0);
      chk($sformatf("rst_par[d%0d]", i), par_v[i], 1'b0);
      chk($sformatf("rst_done[d%0d]", i), done_v[i], 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) send(tv[i], 1'b0);
    valid_v = '0;
    @(posedge clk); #1;

    // x churns and valid stays high while busy: frame unaffected, no restart
    send(mk(0, 3'd6, "001101", 1'b0), 1'b1);
    valid_v = '0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post_busy[c%0d]", k), busy_v[0], 1'b0);
      chk($sformatf("post_tx[c%0d]", k), tx_v[0], 1'b1);
      @(posedge clk); #1;
    end

    // reset during DATA aborts the frame
    x_a[0] = 3'b001;
    valid_v = 3'b001;
    @(posedge clk); #1;
    valid_v = '0;
    @(posedge clk); #1;
    chk("abort_in_data_busy", busy_v[0], 1'b1);
    chk("abort_in_data_tx", tx_v[0], 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_tx", tx_v[0], 1'b1);
    chk("abort_ready", ready_v[0], 1'b1);
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_par", par_v[0], 1'b0);
    chk("abort_done", done_v[0], 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("abort_quiet_done[c%0d]", k), done_v[0], 1'b0);
      chk($sformatf("abort_quiet_tx[c%0d]", k), tx_v[0], 1'b1);
      @(posedge clk); #1;
    end
    send(mk(0, 3'b001, "010011", 1'b1), 1'b0);
    valid_v = '0;
    @(posedge clk); #1;

    // reset wins over a simultaneous valid
    rst = 1'b1;
    valid_v = 3'b001;
    x_a[0] = 3'b111;
    @(posedge clk); #1;
    rst = 1'b0;
    valid_v = '0;
    chk("rstvalid_busy", busy_v[0], 1'b0);
    chk("rstvalid_ready", ready_v[0], 1'b1);
    chk("rstvalid_tx", tx_v[0], 1'b1);
    @(posedge clk); #1;
    chk("rstvalid_busy2", busy_v[0], 1'b0);
    chk("rstvalid_tx2", tx_v[0], 1'b1);
    chk("rstvalid_par", par_v[0], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
